// File: rtl/ntt_bu_sched.sv
// ntt_bu_sched: stage/address scheduler for one 256-point Kyber NTT / iNTT.
// Issues one butterfly read per cycle, carries each butterfly's addresses
// through RD_LAT + BU_LAT cycles, then presents write-back addresses.
// Optional macro NTT_SCHED_STALL_EN adds stall_i, which pauses issue only.
module ntt_bu_sched #(
  parameter int BU_LAT = 7,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
`ifdef NTT_SCHED_STALL_EN
  input  logic              stall_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              is_ntt_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic [6:0]        zeta_addr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_a_o,
  output logic [ADDR_W-1:0] wr_addr_b_o
);

  // Handshake: none. start_i is a one-cycle pulse sampled only in IDLE;
  // rd_en_o / wr_en_o are strobes the datapath must act on in that cycle.

  localparam int L = RD_LAT + BU_LAT;  // must be >= 3
  localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(1 << (ADDR_W - 1));
  localparam logic [ADDR_W-1:0] LEN_MIN = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [ADDR_W-2:0] CNT_MAX = '1;
  localparam logic [2:0]        LAST_STAGE = 3'(ADDR_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic              r_mode;
  logic              r_busy;
  logic              r_done;
  logic [2:0]        r_stage;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W-1:0] r_off;
  logic [ADDR_W-2:0] r_cnt;
  logic [6:0]        r_k;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_a;
  logic [ADDR_W-1:0] r_rd_b;
  logic [6:0]        r_zeta;
  logic [L-1:0]      r_pv;
  logic [ADDR_W-1:0] r_pa [L];
  logic [ADDR_W-1:0] r_pb [L];

  logic              w_stall;
  logic              w_inflight;
  logic [ADDR_W-1:0] w_j;
  logic              w_grp_end;

`ifdef NTT_SCHED_STALL_EN
  assign w_stall = stall_i;
`else
  assign w_stall = 1'b0;
`endif

  assign w_j       = r_start + r_off;
  assign w_grp_end = (r_off == (r_len - ONE_A));

  // DRAIN may leave in the cycle the stage's last write shifts into the
  // output register, so the next stage's first read follows that write
  // by exactly one cycle.
  assign w_inflight = r_rd_en | (|r_pv[L-3:0]);

  // Control FSM, issue counters and registered read-side outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_stage <= '0;
      r_len   <= '0;
      r_start <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_zeta  <= '0;
    end else begin
      r_busy  <= (r_state != S_IDLE);
      r_done  <= (r_state == S_DONE);
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode  <= mode_i;
            r_stage <= '0;
            r_len   <= mode_i ? LEN_MAX : LEN_MIN;
            r_start <= '0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_k     <= mode_i ? 7'd1 : 7'd127;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!w_stall) begin
            r_rd_en <= 1'b1;
            r_rd_a  <= w_j;
            r_rd_b  <= w_j + r_len;
            r_zeta  <= r_k;
            // The last group of a stage ends at 256, so r_start wraps to 0.
            if (w_grp_end) begin
              r_off   <= '0;
              r_start <= r_start + (r_len << 1);
              r_k     <= r_mode ? (r_k + 7'd1) : (r_k - 7'd1);
            end else begin
              r_off   <= r_off + ONE_A;
            end
            r_cnt <= r_cnt + (ADDR_W-1)'(1);
            if (r_cnt == CNT_MAX) begin
              r_len   <= r_mode ? (r_len >> 1) : (r_len << 1);
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!w_inflight) begin
            if (r_stage == LAST_STAGE) begin
              r_state <= S_DONE;
            end else begin
              r_stage <= r_stage + 3'd1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline: each issued butterfly re-emerges as a write L cycles later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pv <= '0;
      for (int i = 0; i < L; i++) begin
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_pv    <= {r_pv[L-2:0], r_rd_en};
      r_pa[0] <= r_rd_a;
      r_pb[0] <= r_rd_b;
      for (int i = 1; i < L; i++) begin
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign is_ntt_o    = r_mode;
  assign rd_en_o     = r_rd_en;
  assign rd_addr_a_o = r_rd_a;
  assign rd_addr_b_o = r_rd_b;
  assign zeta_addr_o = r_zeta;
  assign wr_en_o     = r_pv[L-1];
  assign wr_addr_a_o = r_pa[L-1];
  assign wr_addr_b_o = r_pb[L-1];

endmodule

// File: tb/tb_ntt_bu_sched.sv
// Bench for ntt_bu_sched: reference schedule built from nested stage/group/j
// loops feeds expected queues; a negedge monitor pops and compares.
module tb_ntt_bu_sched;
  localparam int L    = 8;
  localparam int RD_W = 35;  // {cycle[11:0], a[7:0], b[7:0], k[6:0]}
  localparam int WR_W = 28;  // {cycle[11:0], a[7:0], b[7:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
`ifdef NTT_SCHED_STALL_EN
  logic       stall = 1'b0;
`endif
  logic       busy_o, done_o, is_ntt_o, rd_en_o, wr_en_o;
  logic [7:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
  logic [6:0] zeta_addr_o;

  ntt_bu_sched dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .mode_i      (mode),
`ifdef NTT_SCHED_STALL_EN
    .stall_i     (stall),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .is_ntt_o    (is_ntt_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .zeta_addr_o (zeta_addr_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int t0 = 0;
  logic exp_mode = 1'b0;
  logic [RD_W-1:0] rd_q[$];
  logic [WR_W-1:0] wr_q[$];
  int done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference schedule: loops straight over stages, groups and j.
  // Issue cycle of butterfly i of stage s is s*(128+L)+1+i, pushed later by
  // st_len cycles once it reaches the stalled window.
  task automatic build(input logic m, input int st_from, input int st_len);
    int n, len, k, c;
    logic [7:0] a, b;
    logic [6:0] kk;
    logic [11:0] cc, cw;
    n = 0;
    k = m ? 1 : 127;
    for (int s = 0; s < 7; s++) begin
      len = m ? (128 >> s) : (2 << s);
      for (int g = 0; g < 256; g += 2 * len) begin
        for (int j = g; j < g + len; j++) begin
          c = s * (128 + L) + 1 + (n - s * 128);
          if (st_len > 0 && c >= st_from) c += st_len;
          a = j[7:0];
          b = 8'(j + len);
          kk = k[6:0];
          cc = c[11:0];
          cw = 12'(c + L);
          rd_q.push_back({cc, a, b, kk});
          wr_q.push_back({cw, a, b});
          n++;
        end
        k = m ? k + 1 : k - 1;
      end
    end
    done_q.push_back(7 * (128 + L) + 1 + st_len);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [RD_W-1:0] er;
    logic [WR_W-1:0] ew;
    int rel;
    int ed;
    if (!rst) begin
      rel = cyc - t0 - 1;
      if (rd_en_o) begin
        if (rd_q.size() == 0) chk("rd_unexpected", rd_en_o, 0);
        else begin
          er = rd_q.pop_front();
          chk("rd_cycle", rel, er[34:23]);
          chk("rd_addr_a", rd_addr_a_o, er[22:15]);
          chk("rd_addr_b", rd_addr_b_o, er[14:7]);
          chk("zeta_addr", zeta_addr_o, er[6:0]);
          chk("is_ntt", is_ntt_o, exp_mode);
        end
      end
      if (wr_en_o) begin
        if (wr_q.size() == 0) chk("wr_unexpected", wr_en_o, 0);
        else begin
          ew = wr_q.pop_front();
          chk("wr_cycle", rel, ew[27:16]);
          chk("wr_addr_a", wr_addr_a_o, ew[15:8]);
          chk("wr_addr_b", wr_addr_b_o, ew[7:0]);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) chk("done_unexpected", done_o, 0);
        else begin
          ed = done_q.pop_front();
          chk("done_cycle", rel, ed);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Full transform; xs > 0 injects a flipped-mode start sampled at cycle xs.
  task automatic run_xform(input logic m, input int xs, input int st_from, input int st_len);
    int rel;
    bit got;
    build(m, st_from, st_len);
    exp_mode = m;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    t0    = cyc;
    got   = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rel   = cyc - t0 - 1;
      start = (xs > 0 && rel == xs - 1);
      mode  = start ? ~m : 1'($urandom);
`ifdef NTT_SCHED_STALL_EN
      stall = (st_len > 0 && rel >= st_from - 1 && rel < st_from - 1 + st_len);
`endif
      if (rel == 1) chk("busy_on", busy_o, 1);
      if (done_o) begin
        chk("busy_at_done", busy_o, 1);
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("busy_off", busy_o, 0);
    chk("done_off", done_o, 0);
    chk("is_ntt_held", is_ntt_o, m);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
  endtask

  // Start a transform, then assert reset asynchronously at cycle at.
  task automatic abort_run(input logic m, input int at);
    int rel;
    build(m, 0, 0);
    exp_mode = m;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    do begin
      @(negedge clk);
      rel = cyc - t0 - 1;
    end while (rel < at - 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_is_ntt", is_ntt_o, 0);
    chk("rst_rd_addr_a", rd_addr_a_o, 0);
    chk("rst_wr_addr_b", wr_addr_b_o, 0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_wr_en", wr_en_o, 0);
      chk("post_rst_rd_en", rd_en_o, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_is_ntt", is_ntt_o, 0);
    chk("reset_rd_en", rd_en_o, 0);
    chk("reset_wr_en", wr_en_o, 0);
    chk("reset_zeta", zeta_addr_o, 0);

    run_xform(1'b1, 50, 0, 0);   // NTT, ignored flipped start at 50
    run_xform(1'b0, 0, 0, 0);    // iNTT
    abort_run(1'b1, 300);
    run_xform(1'b1, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      run_xform(1'($urandom), $urandom_range(2, 950), 0, 0);
    end
`ifdef NTT_SCHED_STALL_EN
    run_xform(1'b1, 0, 10, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the run above is far shorter than this bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
